// File: rtl/tick_pkg.sv
// Shared definitions for the tick receiver: FSM encoding and default sizing.
// The state values are also visible on the debug port, so the encoding is fixed.
package tick_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StRun  = 2'd2,
        StLost = 2'd3
    } tick_state_e;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 300_000_000;
    localparam int unsigned CNT_W_DEFAULT       = 8;
    localparam int unsigned WD_W                = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/tick_receiver.sv
// Receives a slow toggling tick from another clock domain, emits one step pulse per
// accepted edge, counts them, and flags a lost source via a watchdog.
module tick_receiver
    import tick_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tog_in,
    input  logic             en,
    input  logic             clr,
    output logic             step,
    output logic [CNT_W-1:0] tick_cnt,
    output logic             timeout,
    output logic [1:0]       state
);

    localparam logic [WD_W-1:0] WdLast = WD_W'(TIMEOUT_CYC - 1);

    logic             s2;
    logic             s3_q;
    logic             tog_edge;
    logic             wd_expired;
    logic             enter_lost;

    tick_state_e      state_q;
    tick_state_e      state_d;
    logic [WD_W-1:0]  wd_q;
    logic [WD_W-1:0]  wd_d;
    logic             step_q;
    logic             step_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;
    logic             timeout_d;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tog_in),
        .q     (s2)
    );

    // s3 tracks s2 in every state so edges seen while idle are silently consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_q <= 1'b0;
        end else begin
            s3_q <= s2;
        end
    end

    assign tog_edge   = s2 ^ s3_q;
    assign wd_expired = (wd_q == WdLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // An edge always beats a watchdog expiry landing on the same cycle.
    always_comb begin
        state_d    = state_q;
        wd_d       = wd_q;
        step_d     = 1'b0;
        enter_lost = 1'b0;
        if (!en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StArm;
                    wd_d    = '0;
                end
                StArm: begin
                    if (tog_edge) begin
                        state_d = StRun;
                        wd_d    = '0;
                        step_d  = 1'b1;
                    end else if (wd_expired) begin
                        state_d    = StLost;
                        enter_lost = 1'b1;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                StRun: begin
                    if (tog_edge) begin
                        wd_d   = '0;
                        step_d = 1'b1;
                    end else if (wd_expired) begin
                        state_d    = StLost;
                        enter_lost = 1'b1;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                StLost: begin
                    if (tog_edge) begin
                        state_d = StRun;
                        wd_d    = '0;
                        step_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // A clear coinciding with a step keeps that step, so the count restarts at one.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (clr) begin
            cnt_d     = step_q ? CNT_W'(1) : '0;
            timeout_d = 1'b0;
        end else if (step_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (enter_lost) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q      <= '0;
            step_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign step     = step_q;
    assign tick_cnt = cnt_q;
    assign timeout  = timeout_q;
    assign state    = state_q;

endmodule

// File: tb/tb_tick_receiver.sv
// Directed self-checking bench for tick_receiver with a short watchdog and 4-bit counter.
module tb_tick_receiver;

    logic       clk;
    logic       rst_n;
    logic       tog_in;
    logic       en;
    logic       clr;
    logic       step;
    logic [3:0] tick_cnt;
    logic       timeout;
    logic [1:0] state;

    int n_cmp;
    int n_bad;
    int steps_seen;

    tick_receiver #(
        .TIMEOUT_CYC (20),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tog_in   (tog_in),
        .en       (en),
        .clr      (clr),
        .step     (step),
        .tick_cnt (tick_cnt),
        .timeout  (timeout),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Toggle now; step must pulse exactly on the third cycle, then the count updates.
    task automatic send_tick(input int exp_cnt, input int gap);
        tog_in = ~tog_in;
        cyc(2);
        check("step_early", 32'(step), 32'd0);
        cyc(1);
        check("step_pulse", 32'(step), 32'd1);
        cyc(1);
        check("step_end", 32'(step), 32'd0);
        check("tick_cnt", 32'(tick_cnt), 32'(exp_cnt));
        cyc(gap - 4);
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        tog_in = 1'b0;
        en     = 1'b0;
        clr    = 1'b0;
        cyc(2);
        check("rst_step", 32'(step), 32'd0);
        check("rst_cnt", 32'(tick_cnt), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_state", 32'(state), 32'd0);

        // Regular ticks every 8 cycles.
        rst_n = 1'b1;
        en    = 1'b1;
        cyc(1);
        check("arm_state", 32'(state), 32'd1);
        for (int i = 0; i < 5; i++) send_tick(i + 1, 8);
        check("run_cnt", 32'(tick_cnt), 32'd5);
        check("run_timeout", 32'(timeout), 32'd0);
        check("run_state", 32'(state), 32'd2);

        // Static source: ARM for 20 cycles, then LOST.
        en  = 1'b0;
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("idle_state", 32'(state), 32'd0);
        check("clr_cnt", 32'(tick_cnt), 32'd0);
        en = 1'b1;
        cyc(20);
        check("arm_hold", 32'(state), 32'd1);
        check("arm_no_to", 32'(timeout), 32'd0);
        cyc(1);
        check("lost_state", 32'(state), 32'd3);
        check("lost_timeout", 32'(timeout), 32'd1);
        cyc(5);
        check("lost_stays", 32'(state), 32'd3);
        send_tick(1, 8);
        check("recover_state", 32'(state), 32'd2);
        check("recover_sticky", 32'(timeout), 32'd1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("clr_timeout", 32'(timeout), 32'd0);
        check("clr_cnt2", 32'(tick_cnt), 32'd0);

        // 17 ticks wrap the 4-bit counter to 1.
        for (int i = 0; i < 17; i++) send_tick((i + 1) % 16, 8);
        check("wrap_timeout", 32'(timeout), 32'd0);
        check("wrap_state", 32'(state), 32'd2);

        // Edge lands exactly on the watchdog expiry cycle.
        send_tick(2, 20);
        send_tick(3, 8);
        check("race_state", 32'(state), 32'd2);
        check("race_timeout", 32'(timeout), 32'd0);

        // en drops during a step cycle: that step still counts, later ones do not.
        tog_in = ~tog_in;
        cyc(3);
        check("late_step", 32'(step), 32'd1);
        en = 1'b0;
        cyc(1);
        check("late_cnt", 32'(tick_cnt), 32'd4);
        check("late_state", 32'(state), 32'd0);
        steps_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tog_in = ~tog_in;
            for (int j = 0; j < 8; j++) begin
                cyc(1);
                if (step) steps_seen++;
            end
        end
        check("idle_steps", 32'(steps_seen), 32'd0);
        check("idle_cnt", 32'(tick_cnt), 32'd4);
        check("idle_state2", 32'(state), 32'd0);
        en = 1'b1;
        cyc(1);
        check("rearm_state", 32'(state), 32'd1);

        // Asynchronous reset with tick_cnt=9.
        for (int i = 0; i < 5; i++) send_tick(5 + i, 8);
        check("pre_rst_cnt", 32'(tick_cnt), 32'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_step", 32'(step), 32'd0);
        check("arst_cnt", 32'(tick_cnt), 32'd0);
        check("arst_timeout", 32'(timeout), 32'd0);
        check("arst_state", 32'(state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        steps_seen = 0;
        for (int j = 0; j < 4; j++) begin
            cyc(1);
            if (step) steps_seen++;
        end
        check("post_rst_steps", 32'(steps_seen), 32'd0);
        check("post_rst_state", 32'(state), 32'd1);
        check("post_rst_cnt", 32'(tick_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
